// File: rtl/input_buffer_fifo.sv
// input_buffer_fifo: router input-port flit buffer.
// Stores valid-tagged flits from the link in a DEPTH-entry circular FIFO,
// presents the head flit to the crossbar, pops it on request and returns
// one credit upstream per pop. Overflow of a full buffer sets a sticky flag.
//
// Optional build macro: INPUT_BUFFER_BYPASS_EN
//   When defined, a valid flit arriving at an empty buffer is driven
//   straight to data_o in the same cycle. If it is also popped that cycle,
//   it is consumed without being written.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   data_i       incoming flit, bit DATA_W = valid, DATA_W-1:0 = payload
//   data_send_i  downstream pop request for the head flit
//   data_o       head flit, valid bit set when non-empty, all zero when empty
//   count_o      current occupancy, 0..DEPTH
//   full_o       occupancy equals DEPTH
//   empty_o      occupancy equals zero
//   credit_o     registered one-cycle pulse following each accepted pop
//   overflow_o   sticky, a valid flit was dropped while full

module input_buffer_fifo #(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W:0]   data_i,
    input  logic              data_send_i,
    output logic [DATA_W:0]   data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              credit_o,
    output logic              overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("input_buffer_fifo: DEPTH must be a power of two in 2..64");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic             in_vld;
    logic             full;
    logic             empty;
    logic             pop;
    logic             byp;
    logic             push;
    logic [DATA_W:0]  head;

    assign in_vld = data_i[DATA_W];
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);

    // A pop only touches storage when something is stored.
    assign pop = data_send_i & ~empty;

`ifdef INPUT_BUFFER_BYPASS_EN
    // Cut-through: flit consumed in the cycle it arrives, never stored.
    assign byp = empty & in_vld & data_send_i;
`else
    assign byp = 1'b0;
`endif

    // A full buffer still accepts when the head leaves the same cycle.
    assign push = in_vld & (~full | pop) & ~byp;

    assign head = empty ? '0 : {1'b1, mem_q[rd_ptr_q]};

`ifdef INPUT_BUFFER_BYPASS_EN
    assign data_o = (empty & in_vld) ? data_i : head;
`else
    assign data_o = head;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop | byp;
        overflow_d = overflow_q | (in_vld & full & ~pop);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the valid view comes from count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= data_i[DATA_W-1:0];
        end
    end

    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;

endmodule
